// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked data-memory responder with fixed latency and byte-enabled writes
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [3:0]       req_be,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             accept;
    logic             commit;
    logic             cur_we;
    logic [WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0] cur_wdata;
    logic [3:0]       cur_be;
    logic             addr_err;
    logic [AW-1:0]    word_idx;

    assign accept = (state_q == IDLE) && req_valid;
    assign commit = (state_d == RESP) && (state_q != RESP);

    // With LATENCY == 1 the commit coincides with the accept edge, so the live request is used.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign addr_err = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[WIDTH-1:2]} >= WIDTH'(DEPTH));
    assign word_idx = cur_addr[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (cnt_q == CW'(1)) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
            cnt_d   = CW'(LATENCY - 1);
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (commit) begin
            err_d   = addr_err;
            rdata_d = (!addr_err && !cur_we) ? mem_q[word_idx] : '0;
        end
    end

    // Array has no reset; reset gating keeps an accept-while-in-reset from committing.
    always_ff @(posedge clk) begin
        if (commit && !addr_err && cur_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem_q[word_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule
